// File: rtl/sipo_shiftreg.sv
// Serial-in/parallel-out receive shift register with a storage register,
// frame counting and valid/overrun handshake towards the consuming logic.
module sipo_shiftreg #(
  parameter int WIDTH      = 8,
  parameter bit AUTO_LATCH = 1'b1
) (
  input  logic                         CLK,
  input  logic                         CLRb,
  input  logic                         SER,
  input  logic                         SH,
  input  logic                         CLK_INH,
  input  logic                         LATCH,
  input  logic                         ACK,
  input  logic                         OEb,
  output logic [WIDTH-1:0]             Q,
  output logic                         QHs,
  output logic [$clog2(WIDTH+1)-1:0]   BIT_CNT,
  output logic                         FRAME_DONE,
  output logic                         VALID,
  output logic                         OVERRUN
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_store;
  logic [CW-1:0]    r_cnt;
  logic             r_frameDone;
  logic             r_valid;
  logic             r_overrun;

  logic             w_shift;
  logic             w_autoLoad;
  logic             w_load;
  logic [WIDTH-1:0] w_srNext;
  logic [CW-1:0]    w_cntNext;

  assign w_shift    = SH & ~CLK_INH;
  assign w_srNext   = w_shift ? {r_sr[WIDTH-2:0], SER} : r_sr;
  assign w_autoLoad = AUTO_LATCH && w_shift && (r_cnt == LAST_BIT);
  // A manual LATCH on the same edge as an auto latch collapses into one load.
  assign w_load     = w_autoLoad | LATCH;

  // Auto-latch builds wrap to zero at the frame end; manual builds saturate.
  always_comb begin
    w_cntNext = r_cnt;
    if (w_load) begin
      w_cntNext = '0;
    end else if (w_shift && (r_cnt != FULL_CNT)) begin
      w_cntNext = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      r_sr        <= '0;
      r_store     <= '0;
      r_cnt       <= '0;
      r_frameDone <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sr        <= w_srNext;
      r_cnt       <= w_cntNext;
      r_frameDone <= w_autoLoad;
      if (w_load) begin
        r_store <= w_srNext;
      end
      // A load always wins over a same-edge ACK and never counts as overrun then.
      if (w_load && r_valid && !ACK) begin
        r_overrun <= 1'b1;
      end
      if (w_load) begin
        r_valid <= 1'b1;
      end else if (ACK) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign Q          = OEb ? '0 : r_store;
  assign QHs        = r_sr[WIDTH-1];
  assign BIT_CNT    = r_cnt;
  assign FRAME_DONE = r_frameDone;
  assign VALID      = r_valid;
  assign OVERRUN    = r_overrun;

endmodule

// File: tb/tb_sipo_shiftreg.sv
// Self-checking bench for sipo_shiftreg: an auto-latch and a manual-latch
// instance share stimulus and are compared every cycle against a bit-history model.
module tb_sipo_shiftreg;

  localparam int W = 8;

  logic clk = 1'b0;
  logic clrB, ser, sh, clkInh, latch, ack, oeB;

  logic [W-1:0] qA, qM;
  logic         qhsA, qhsM;
  logic [3:0]   cntA, cntM;
  logic         fdA, fdM, validA, validM, ovrA, ovrM;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Model state, index 1 = auto-latch instance, index 0 = manual instance.
  int mHist[2];
  int mStore[2];
  int mCnt[2];
  bit mFd[2], mValid[2], mOvr[2];

  sipo_shiftreg #(.WIDTH(W), .AUTO_LATCH(1'b1)) dutAuto (
    .CLK(clk), .CLRb(clrB), .SER(ser), .SH(sh), .CLK_INH(clkInh),
    .LATCH(latch), .ACK(ack), .OEb(oeB),
    .Q(qA), .QHs(qhsA), .BIT_CNT(cntA), .FRAME_DONE(fdA),
    .VALID(validA), .OVERRUN(ovrA)
  );

  sipo_shiftreg #(.WIDTH(W), .AUTO_LATCH(1'b0)) dutManual (
    .CLK(clk), .CLRb(clrB), .SER(ser), .SH(sh), .CLK_INH(clkInh),
    .LATCH(latch), .ACK(ack), .OEb(oeB),
    .Q(qM), .QHs(qhsM), .BIT_CNT(cntM), .FRAME_DONE(fdM),
    .VALID(validM), .OVERRUN(ovrM)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void resetModel();
    for (int k = 0; k < 2; k++) begin
      mHist[k] = 0; mStore[k] = 0; mCnt[k] = 0;
      mFd[k] = 0; mValid[k] = 0; mOvr[k] = 0;
    end
  endfunction

  // One clock edge of the receiver: count received bits, complete a frame when
  // W of them have arrived (auto build), and load storage with the last W bits.
  function automatic void stepModel(int k, bit autoMode);
    bit doShift, frameEnd, load;
    doShift = sh && !clkInh;
    if (doShift) begin
      mHist[k] = ((mHist[k] * 2) + int'(ser)) % (1 << W);
      mCnt[k]  = mCnt[k] + 1;
    end
    frameEnd = autoMode && doShift && (mCnt[k] == W);
    load     = frameEnd || latch;
    if (load && mValid[k] && !ack) mOvr[k] = 1;
    if (load) mValid[k] = 1;
    else if (ack) mValid[k] = 0;
    if (load) begin
      mStore[k] = mHist[k];
      mCnt[k]   = 0;
    end else if (mCnt[k] > W) begin
      mCnt[k] = W;
    end
    mFd[k] = frameEnd;
  endfunction

  always @(negedge clrB) resetModel();

  always @(posedge clk) begin
    if (clrB) begin
      stepModel(1, 1'b1);
      stepModel(0, 1'b0);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #2;
    if (started) begin
      checkOutput("autoQ",     32'(qA),     oeB ? 0 : mStore[1]);
      checkOutput("autoQHs",   32'(qhsA),   (mHist[1] >> (W-1)) & 1);
      checkOutput("autoCnt",   32'(cntA),   mCnt[1]);
      checkOutput("autoFd",    32'(fdA),    32'(mFd[1]));
      checkOutput("autoValid", 32'(validA), 32'(mValid[1]));
      checkOutput("autoOvr",   32'(ovrA),   32'(mOvr[1]));
      checkOutput("manQ",      32'(qM),     oeB ? 0 : mStore[0]);
      checkOutput("manQHs",    32'(qhsM),   (mHist[0] >> (W-1)) & 1);
      checkOutput("manCnt",    32'(cntM),   mCnt[0]);
      checkOutput("manFd",     32'(fdM),    32'(mFd[0]));
      checkOutput("manValid",  32'(validM), 32'(mValid[0]));
      checkOutput("manOvr",    32'(ovrM),   32'(mOvr[0]));
    end
  end

  task automatic applyStimulus(input bit s, input bit d, input bit inh, input bit lt, input bit ak);
    @(negedge clk);
    sh = s; ser = d; clkInh = inh; latch = lt; ack = ak;
    @(posedge clk);
    #3;
  endtask

  task automatic shiftBits(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, v[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1 clrB = 1'b0;
    #1;
    checkOutput("rstQ",     32'(qA),     0);
    checkOutput("rstCnt",   32'(cntA),   0);
    checkOutput("rstValid", 32'(validA), 0);
    checkOutput("rstOvr",   32'(ovrA),   0);
    checkOutput("rstFd",    32'(fdA),    0);
    checkOutput("rstQHs",   32'(qhsA),   0);
    @(negedge clk);
    clrB = 1'b1;
    sh = 0; ser = 0; clkInh = 0; latch = 0; ack = 0; oeB = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clrB = 0; ser = 0; sh = 0; clkInh = 0; latch = 0; ack = 0; oeB = 0;
    resetModel();
    repeat (2) @(posedge clk);
    doReset();
    started = 1;

    // Asynchronous clear in the middle of a frame.
    shiftBits(16'b101, 3);
    checkOutput("midFrameCnt", 32'(cntA), 3);
    doReset();

    // Full frame with automatic latch.
    shiftBits(16'b11010101, 8);
    checkOutput("frameQ",     32'(qA),     32'hD5);
    checkOutput("frameFd",    32'(fdA),    1);
    checkOutput("frameValid", 32'(validA), 1);
    checkOutput("frameCnt",   32'(cntA),   0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("frameFdOff", 32'(fdA),    0);

    // Clock inhibit holds shifting and counting.
    doReset();
    shiftBits(16'b011, 3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("inhCnt", 32'(cntA), 3);
    end
    shiftBits(16'b10000, 5);
    checkOutput("inhQ", 32'(qA), 32'h70);

    // Overrun and acknowledge.
    doReset();
    shiftBits(16'h61, 8);
    checkOutput("ovrFirstQ", 32'(qA), 32'h61);
    shiftBits(16'h24, 8);
    checkOutput("ovrQ",   32'(qA),   32'h24);
    checkOutput("ovrSet", 32'(ovrA), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ackValid", 32'(validA), 0);
    checkOutput("ackOvr",   32'(ovrA),   1);
    shiftBits(16'h12, 7);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("ackLoadValid", 32'(validA), 1);
    checkOutput("ackLoadOvr",   32'(ovrA),   1);
    doReset();
    shiftBits(16'h3C, 8);
    shiftBits(16'h2A, 7);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ackWinQ",     32'(qA),     32'h54);
    checkOutput("ackWinValid", 32'(validA), 1);
    checkOutput("ackWinOvr",   32'(ovrA),   0);

    // Manual latch and output enable.
    doReset();
    shiftBits(16'b101, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("latchQ",   32'(qA),   32'h05);
    checkOutput("latchCnt", 32'(cntA), 0);
    checkOutput("latchFd",  32'(fdA),  0);
    @(negedge clk); oeB = 1'b1; #1;
    checkOutput("oebQ", 32'(qA), 0);
    @(negedge clk); oeB = 1'b0; #1;
    checkOutput("oebBackQ", 32'(qA), 32'h05);

    // Manual-only instance saturates and waits for LATCH.
    doReset();
    shiftBits(16'b1011001011, 10);
    checkOutput("satCnt", 32'(cntM), 8);
    checkOutput("satQ",   32'(qM),   0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("satLatchQ", 32'(qM), 32'hCB);

    // Randomized traffic, including inhibit-time latches and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      @(negedge clk);
      oeB = ($urandom_range(0, 9) == 0);
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom),
                    $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 4) == 0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
